frog_move_conditioner: RTL

Input-conditioning stage between the four Go Board switches and the frog movement controller. It synchronises and debounces each switch, arbitrates simultaneous presses, and emits single-cycle move pulses: one on press, then auto-repeat while held. It also enforces a release lockout after a game reset, so a death or win never turns into an unintended move.

---
 rtl/frog_move_conditioner.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/frog_move_conditioner.sv
// Conditions the four Go Board switches into single-cycle frog move pulses:
// 2-flop sync, per-switch debounce, priority arbitration, auto-repeat and reset lockout.
module frog_move_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  input  logic       game_reset,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKOUT} state_t;

  logic [3:0]       sw_raw;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       acc_q;
  logic [CNT_W-1:0] deb_cnt_q [4];

  assign sw_raw = {switch4, switch3, switch2, switch1};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_switch
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_q[gi]   <= 1'b0;
          sync2_q[gi]   <= 1'b0;
          acc_q[gi]     <= 1'b0;
          deb_cnt_q[gi] <= '0;
        end else begin
          sync1_q[gi] <= sw_raw[gi];
          sync2_q[gi] <= sync1_q[gi];
          // The counter only runs while the synchronised level disagrees with the accepted one.
          if (sync2_q[gi] == acc_q[gi]) begin
            deb_cnt_q[gi] <= '0;
          end else if (deb_cnt_q[gi] == DEB_LAST) begin
            acc_q[gi]     <= sync2_q[gi];
            deb_cnt_q[gi] <= '0;
          end else begin
            deb_cnt_q[gi] <= deb_cnt_q[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  logic       any_acc;
  logic [1:0] win;

  assign any_acc = |acc_q;

  always_comb begin
    win = 2'd3;
    if (acc_q[0])      win = 2'd0;
    else if (acc_q[1]) win = 2'd1;
    else if (acc_q[2]) win = 2'd2;
  end

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       pulse_q, pulse_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    pulse_d = 4'b0000;
    timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (any_acc) begin
          pulse_d[win] = 1'b1;
          sel_d        = win;
          dir_d        = win;
          timer_d      = '0;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (!acc_q[sel_q]) begin
          state_d = IDLE;
        end else if (timer_q == DELAY_LAST) begin
          pulse_d[sel_q] = 1'b1;
          dir_d          = sel_q;
          timer_d        = '0;
          state_d        = REPEAT;
        end
      end
      REPEAT: begin
        if (!acc_q[sel_q]) begin
          state_d = IDLE;
        end else if (timer_q == PERIOD_LAST) begin
          pulse_d[sel_q] = 1'b1;
          dir_d          = sel_q;
          timer_d        = '0;
        end
      end
      LOCKOUT: begin
        if (!any_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A death or win wins over everything, including a pulse due this cycle.
    if (game_reset) begin
      state_d = LOCKOUT;
      timer_d = '0;
      pulse_d = 4'b0000;
      dir_d   = dir_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      dir_q   <= 2'd0;
      timer_q <= '0;
      pulse_q <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign move_up    = pulse_q[0];
  assign move_down  = pulse_q[1];
  assign move_left  = pulse_q[2];
  assign move_right = pulse_q[3];
  assign move_valid = |pulse_q;
  assign move_dir   = dir_q;
  assign busy       = busy_q;

endmodule
